// File: rtl/i2s_tx_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_tx_sequencer
//
// Drains 32-bit words {left[15:0], right[15:0]} from the I2S output FIFO and
// serializes each one as a single Philips-I2S stereo frame, MSB first. WS
// leads the data by one bit. One word is prefetched per frame. When no word
// is ready at a frame boundary, silence is sent and an underrun is reported.
//
// Optional build macro:
//   UNDERRUN_REPEAT_EN  - on underrun, replay the last loaded word instead of
//                         sending silence (the underrun reporting is unchanged)
//
// Parameters:
//   CLK_DIV        clk cycles per SCK half-period (2..255)
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   en             streaming enable (level); stopping takes effect at a frame end
//   fifo_out_data  FIFO read data, valid the cycle after a pop
//   fifo_out_rts   FIFO non-empty
//   fifo_out_rtr   pop request to the FIFO
//   i2s_sck        serial bit clock
//   i2s_ws         word select (0 = left, 1 = right)
//   i2s_sd         serial data, changes on the SCK falling edge
//   busy           main FSM is not idle
//   underrun       one-clk pulse at a frame start with no word ready
//   underrun_cnt   saturating underrun count, cleared only by rst
// ---------------------------------------------------------------------------
module i2s_tx_sequencer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] fifo_out_data,
  input  logic        fifo_out_rts,
  output logic        fifo_out_rtr,
  output logic        i2s_sck,
  output logic        i2s_ws,
  output logic        i2s_sd,
  output logic        busy,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_REQ  = 2'd1;
  localparam logic [1:0] F_CAP  = 2'd2;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0]  state;
  logic [1:0]  fstate;
  logic        next_valid;
  logic [31:0] next_word;
  logic [31:0] shreg;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic        sck;
`ifdef UNDERRUN_REPEAT_EN
  logic [31:0] last_word;
`endif

  assign fifo_out_rtr = (fstate == F_REQ) & fifo_out_rts;
  assign busy         = (state != IDLE);
  assign i2s_sck      = sck;
  assign i2s_ws       = (state == RUN) && (bit_cnt >= 5'd15) && (bit_cnt <= 5'd30);
  assign i2s_sd       = (state == RUN) && shreg[31];

  // Both FSMs share one block: the main FSM starts fetches and consumes
  // next_valid, so its assignments are placed after the fetch FSM's and
  // take priority. A fetch is only started from F_IDLE with next_valid=0,
  // which guarantees a single pop per fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fstate       <= F_IDLE;
      next_valid   <= 1'b0;
      next_word    <= '0;
      shreg        <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sck          <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
`ifdef UNDERRUN_REPEAT_EN
      last_word    <= '0;
`endif
    end else begin
      underrun <= 1'b0;

      case (fstate)
        F_REQ: begin
          if (fifo_out_rts) fstate <= F_CAP;
        end
        F_CAP: begin
          next_word  <= fifo_out_data;
          next_valid <= 1'b1;
          fstate     <= F_IDLE;
        end
        default: fstate <= F_IDLE;
      endcase

      case (state)
        IDLE: begin
          sck     <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (en) begin
            state <= PRIME;
            if (!next_valid && fstate == F_IDLE) fstate <= F_REQ;
          end
        end

        PRIME: begin
          if (next_valid) begin
            shreg      <= next_word;
`ifdef UNDERRUN_REPEAT_EN
            last_word  <= next_word;
`endif
            next_valid <= 1'b0;
            fstate     <= F_REQ;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sck        <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= ~sck;
            // sck currently high: this toggle is the falling edge (shift tick)
            if (sck) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                if (!en) begin
                  state <= IDLE;
                  shreg <= '0;
                end else if (next_valid) begin
                  shreg      <= next_word;
`ifdef UNDERRUN_REPEAT_EN
                  last_word  <= next_word;
`endif
                  next_valid <= 1'b0;
                  fstate     <= F_REQ;
                end else begin
`ifdef UNDERRUN_REPEAT_EN
                  shreg <= last_word;
`else
                  shreg <= '0;
`endif
                  underrun <= 1'b1;
                  if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
                end
              end else begin
                shreg <= {shreg[30:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
`timescale 1ns/1ps
// Directed testbench for i2s_tx_sequencer. A queue-based FIFO model feeds the
// main instance (CLK_DIV=4); a second instance (CLK_DIV=2) with a one-word
// source exercises underrun counter saturation in fewer cycles.
module tb_i2s_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] fdata = '0;
  logic        rts = 1'b0;
  logic        rtr, sck, ws, sd, busy, underrun;
  logic [7:0]  ucnt;

  logic        en2 = 1'b0;
  logic [31:0] fdata2 = 32'h1234_5678;
  logic        rts2 = 1'b0;
  logic        rtr2, sck2, ws2, sd2, busy2, underrun2;
  logic [7:0]  ucnt2;

`ifdef UNDERRUN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  always #5 clk = ~clk;

  i2s_tx_sequencer #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_out_data(fdata), .fifo_out_rts(rts), .fifo_out_rtr(rtr),
    .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
    .busy(busy), .underrun(underrun), .underrun_cnt(ucnt)
  );

  i2s_tx_sequencer #(.CLK_DIV(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en2),
    .fifo_out_data(fdata2), .fifo_out_rts(rts2), .fifo_out_rtr(rtr2),
    .i2s_sck(sck2), .i2s_ws(ws2), .i2s_sd(sd2),
    .busy(busy2), .underrun(underrun2), .underrun_cnt(ucnt2)
  );

  logic [31:0] fq[$];
  bit          sd_q[$];
  bit          ws_q[$];
  int          t_q[$];
  logic        pop_pending = 1'b0;
  logic        pend2 = 1'b0;
  logic        sck_prev = 1'b0;
  logic        arm2 = 1'b0;
  logic        got2 = 1'b0;
  int          cyc = 0;
  int          pops = 0;
  int          ur_pulses = 0;
  int          ur2_pulses = 0;
  int          checks = 0;
  int          passed = 0;

  // FIFO model: the pop decision is sampled on the falling edge, data and
  // rts update on the rising edge like a registered FIFO.
  always @(posedge clk) begin
    if (pop_pending && fq.size() != 0) begin
      fdata <= fq[0];
      void'(fq.pop_front());
      pops <= pops + 1;
    end
    rts <= (fq.size() != 0);
  end

  always @(posedge clk) begin
    if (pend2) begin
      got2 <= 1'b1;
      rts2 <= 1'b0;
    end else begin
      rts2 <= arm2 && !got2;
    end
  end

  // Monitor: records sd/ws at each SCK rising edge with a cycle stamp.
  always @(negedge clk) begin
    cyc         <= cyc + 1;
    sck_prev    <= sck;
    pop_pending <= rtr;
    pend2       <= rtr2;
    if (sck && !sck_prev) begin
      sd_q.push_back(sd);
      ws_q.push_back(ws);
      t_q.push_back(cyc);
    end
    if (underrun)  ur_pulses  <= ur_pulses + 1;
    if (underrun2) ur2_pulses <= ur2_pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    en  = 1'b0;
    en2 = 1'b0;
    fq.delete();
    rst = 1'b1;
    tick(3);
    sd_q.delete();
    ws_q.delete();
    t_q.delete();
    rst = 1'b0;
    tick(3);
  endtask

  task automatic get_bits(input int n, output logic [31:0] d, output logic [31:0] w,
                          output int t0);
    d  = '0;
    w  = '0;
    t0 = -1;
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      while (sd_q.size() == 0 && k < 400) begin
        @(negedge clk);
        k++;
      end
      if (sd_q.size() == 0) begin
        checks++;
        $display("FAIL bit_timeout got no sck edge want bit %0d", i);
        return;
      end
      d = {d[30:0], 1'(sd_q.pop_front())};
      w = {w[30:0], 1'(ws_q.pop_front())};
      if (i == 0) t0 = t_q.pop_front();
      else void'(t_q.pop_front());
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 600) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_idle busy=%b want 0", name, busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({sck, ws, sd, busy, underrun, rtr, ucnt} !== 14'h0)
      $display("FAIL reset_main got %h want 0", {sck, ws, sd, busy, underrun, rtr, ucnt});
    else passed++;
    checks++;
    if ({sck2, ws2, sd2, busy2, underrun2, rtr2, ucnt2} !== 14'h0)
      $display("FAIL reset_sat got %h want 0", {sck2, ws2, sd2, busy2, underrun2, rtr2, ucnt2});
    else passed++;
    rst = 1'b0;
    tick(2);
    checks++;
    if ({sck, ws, sd, busy, rtr} !== 5'h0)
      $display("FAIL reset_release got %b want 00000", {sck, ws, sd, busy, rtr});
    else passed++;
  endtask

  task automatic test_single();
    logic [31:0] d, w;
    int t0, t1, c_en, p0, u0;
    do_reset();
    fq.push_back(32'hA5A5_3C3C);
    tick(3);
    p0 = pops;
    u0 = ur_pulses;
    #1;
    c_en = cyc;
    en = 1'b1;
    get_bits(32, d, w, t0);
    checks++;
    if (t0 - c_en !== 7) $display("FAIL single_latency got %0d want 7", t0 - c_en);
    else passed++;
    checks++;
    if (d !== 32'hA5A5_3C3C) $display("FAIL single_sd got %h want a5a53c3c", d);
    else passed++;
    checks++;
    if (w !== 32'h0001_FFFE) $display("FAIL single_ws got %h want 0001fffe", w);
    else passed++;
    get_bits(32, d, w, t1);
    en = 1'b0;
    checks++;
    if (t1 - t0 !== 256) $display("FAIL single_frame_len got %0d want 256", t1 - t0);
    else passed++;
    checks++;
    if (d !== (REPEAT ? 32'hA5A5_3C3C : 32'h0))
      $display("FAIL single_underrun_fill got %h want %h", d, (REPEAT ? 32'hA5A5_3C3C : 32'h0));
    else passed++;
    checks++;
    if (pops - p0 !== 1) $display("FAIL single_pops got %0d want 1", pops - p0);
    else passed++;
    checks++;
    if (ur_pulses - u0 !== 1) $display("FAIL single_ur_pulse got %0d want 1", ur_pulses - u0);
    else passed++;
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1, d2, w;
    int t0, t1, t2, p0, u0;
    do_reset();
    fq.push_back(32'h1234_5678);
    fq.push_back(32'h9ABC_DEF0);
    fq.push_back(32'h0F0F_00FF);
    tick(3);
    p0 = pops;
    u0 = ur_pulses;
    en = 1'b1;
    get_bits(32, d0, w, t0);
    get_bits(32, d1, w, t1);
    get_bits(32, d2, w, t2);
    en = 1'b0;
    checks++;
    if ({d0, d1, d2} !== {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_00FF})
      $display("FAIL b2b_data got %h %h %h want 12345678 9abcdef0 0f0f00ff", d0, d1, d2);
    else passed++;
    checks++;
    if (t1 - t0 !== 256 || t2 - t1 !== 256)
      $display("FAIL b2b_gap got %0d %0d want 256 256", t1 - t0, t2 - t1);
    else passed++;
    checks++;
    if (ur_pulses - u0 !== 0 || ucnt !== 8'd0)
      $display("FAIL b2b_underrun got %0d cnt %0d want 0 0", ur_pulses - u0, ucnt);
    else passed++;
    wait_idle("b2b");
    checks++;
    if (pops - p0 !== 3) $display("FAIL b2b_pops got %0d want 3", pops - p0);
    else passed++;
  endtask

  task automatic test_underrun();
    logic [31:0] d0, d1, w1;
    int t, u0;
    do_reset();
    fq.push_back(32'hC0DE_1234);
    tick(3);
    u0 = ur_pulses;
    en = 1'b1;
    get_bits(32, d0, w1, t);
    get_bits(32, d1, w1, t);
    en = 1'b0;
    checks++;
    if (d0 !== 32'hC0DE_1234) $display("FAIL ur_frame1 got %h want c0de1234", d0);
    else passed++;
    checks++;
    if (d1 !== (REPEAT ? 32'hC0DE_1234 : 32'h0))
      $display("FAIL ur_frame2 got %h want %h", d1, (REPEAT ? 32'hC0DE_1234 : 32'h0));
    else passed++;
    checks++;
    if (w1 !== 32'h0001_FFFE) $display("FAIL ur_ws got %h want 0001fffe", w1);
    else passed++;
    checks++;
    if (ur_pulses - u0 !== 1 || ucnt !== 8'd1)
      $display("FAIL ur_count got pulses %0d cnt %0d want 1 1", ur_pulses - u0, ucnt);
    else passed++;
    wait_idle("ur");
  endtask

  task automatic test_en_drop();
    logic [31:0] da, db, w;
    int t, p0;
    do_reset();
    fq.push_back(32'hDEAD_BEEF);
    fq.push_back(32'h5A5A_F00D);
    tick(3);
    p0 = pops;
    en = 1'b1;
    get_bits(6, da, w, t);
    en = 1'b0;
    get_bits(26, db, w, t);
    checks++;
    if ({da[5:0], db[25:0]} !== 32'hDEAD_BEEF)
      $display("FAIL drop_frame got %h want deadbeef", {da[5:0], db[25:0]});
    else passed++;
    wait_idle("drop");
    tick(4);
    checks++;
    if ({sck, ws, sd, busy} !== 4'b0000 || sd_q.size() != 0)
      $display("FAIL drop_outputs got %b extra %0d want 0000 0", {sck, ws, sd, busy}, sd_q.size());
    else passed++;
    checks++;
    if (pops - p0 !== 2) $display("FAIL drop_pops got %0d want 2", pops - p0);
    else passed++;
    en = 1'b1;
    get_bits(32, da, w, t);
    en = 1'b0;
    checks++;
    if (da !== 32'h5A5A_F00D) $display("FAIL drop_restart got %h want 5a5af00d", da);
    else passed++;
    wait_idle("drop2");
    checks++;
    if (pops - p0 !== 2) $display("FAIL drop_restart_pops got %0d want 2", pops - p0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, w;
    int t, p0;
    do_reset();
    fq.push_back(32'h1111_2222);
    fq.push_back(32'h3333_4444);
    fq.push_back(32'h5555_6666);
    tick(3);
    en = 1'b1;
    get_bits(10, d, w, t);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({sck, ws, sd, busy, underrun, rtr, ucnt} !== 14'h0)
      $display("FAIL rstmid_outputs got %h want 0", {sck, ws, sd, busy, underrun, rtr, ucnt});
    else passed++;
    tick(2);
    sd_q.delete();
    ws_q.delete();
    t_q.delete();
    p0 = pops;
    rst = 1'b0;
    get_bits(32, d, w, t);
    en = 1'b0;
    checks++;
    if (d !== 32'h5555_6666) $display("FAIL rstmid_restart got %h want 55556666", d);
    else passed++;
    wait_idle("rstmid");
    checks++;
    if (pops - p0 !== 1) $display("FAIL rstmid_pops got %0d want 1", pops - p0);
    else passed++;
  endtask

  task automatic test_saturation();
    int k;
    do_reset();
    arm2 = 1'b1;
    en2  = 1'b1;
    k = 0;
    while (ur2_pulses < 100 && k < 14000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ucnt2 !== 8'd100) $display("FAIL sat_cnt100 got %0d want 100", ucnt2);
    else passed++;
    k = 0;
    while (ur2_pulses < 300 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ur2_pulses < 300) $display("FAIL sat_timeout got %0d pulses want 300", ur2_pulses);
    else passed++;
    checks++;
    if (ucnt2 !== 8'd255) $display("FAIL sat_cnt got %0d want 255", ucnt2);
    else passed++;
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_en_drop();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
